// File: rtl/keypad_pkg.sv
// Shared state encoding, default geometry and gear key codes for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        MULTI   = 2'd2
    } key_state_t;

    localparam int KP_ROWS            = 4;
    localparam int KP_COLS            = 4;
    localparam int KP_DEBOUNCE_FRAMES = 3;
    localparam int KP_REPEAT_DELAY    = 20;
    localparam int KP_REPEAT_PERIOD   = 5;

    // Gear keys share their codes with the display unit's gear_char values.
    localparam int KEY_GEAR_P = 3;
    localparam int KEY_GEAR_R = 6;
    localparam int KEY_GEAR_N = 9;
    localparam int KEY_GEAR_D = 12;

    function automatic logic is_gear_key(input int code);
        return (code == KEY_GEAR_P) || (code == KEY_GEAR_R) ||
               (code == KEY_GEAR_N) || (code == KEY_GEAR_D);
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: counts identical consecutive sweeps and classifies the
// accepted frame as empty, single key (with its row*COLS+col code) or multiple keys.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int ROWS            = KP_ROWS,
    parameter int COLS            = KP_COLS,
    parameter int DEBOUNCE_FRAMES = KP_DEBOUNCE_FRAMES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*COLS-1:0]           frame,
    input  logic                           frame_done,
    output logic                           stable,
    output logic                           is_zero,
    output logic                           is_one,
    output logic                           is_multi,
    output logic [$clog2(ROWS*COLS)-1:0]   index
);

    localparam int N  = ROWS * COLS;
    localparam int KW = $clog2(N);
    localparam int DW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [DW-1:0] DEB_TOP = DW'(DEBOUNCE_FRAMES - 1);

    logic [N-1:0]  prev_frame;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_next;
    logic          same;
    logic          any_bit;

    assign same = (frame == prev_frame);

    always_comb begin
        deb_next = '0;
        if (same) begin
            deb_next = (deb_cnt == DEB_TOP) ? DEB_TOP : deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_frame <= '0;
            deb_cnt    <= '0;
        end else if (frame_done) begin
            prev_frame <= frame;
            deb_cnt    <= deb_next;
        end
    end

    assign stable = frame_done && same && (deb_next == DEB_TOP);

    // Frame bits are column-major (col*ROWS+row); key codes are row-major.
    always_comb begin
        any_bit  = 1'b0;
        is_multi = 1'b0;
        index    = '0;
        for (int i = 0; i < N; i++) begin
            if (frame[i]) begin
                if (any_bit) begin
                    is_multi = 1'b1;
                end
                any_bit = 1'b1;
                index   = KW'((i % ROWS) * COLS + i / ROWS);
            end
        end
    end

    assign is_zero = !any_bit;
    assign is_one  = any_bit && !is_multi;

endmodule

// File: rtl/keypad_scan_unit.sv
// Column-multiplexed key matrix scanner with frame debounce and press/release reporting.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
//
// state   | meaning
// IDLE    | no key accepted
// PRESSED | exactly one key accepted, key_code holds it
// MULTI   | two or more keys stable, nothing reported
module keypad_scan_unit
    import keypad_pkg::*;
#(
    parameter int ROWS            = KP_ROWS,
    parameter int COLS            = KP_COLS,
    parameter int DEBOUNCE_FRAMES = KP_DEBOUNCE_FRAMES,
    parameter int REPEAT_DELAY    = KP_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = KP_REPEAT_PERIOD
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick_scan,
    input  logic [ROWS-1:0]                key_row,
    output logic [COLS-1:0]                key_col,
    output logic [$clog2(ROWS*COLS)-1:0]   key_code,
    output logic                           key_valid,
    output logic                           key_release,
    output logic                           key_held,
    output logic                           key_multi
);

    localparam int N  = ROWS * COLS;
    localparam int KW = $clog2(N);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    if (DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("keypad_scan_unit: DEBOUNCE_FRAMES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [CW-1:0] col_idx;
    logic [N-1:0]  frame;
    logic          frame_done;
    logic          stable;
    logic          is_zero;
    logic          is_one;
    logic          is_multi;
    logic [KW-1:0] index;
    key_state_t    state;

    // Rows are sampled a full tick after their column was driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx    <= '0;
            key_col    <= '1;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            key_col    <= ~(COLS'(1) << col_idx);
            frame_done <= tick_scan && (col_idx == COL_LAST);
            if (tick_scan) begin
                frame[col_idx*ROWS +: ROWS] <= ~key_row;
                col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
            end
        end
    end

    keypad_frame_debounce #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame),
        .frame_done (frame_done),
        .stable     (stable),
        .is_zero    (is_zero),
        .is_one     (is_one),
        .is_multi   (is_multi),
        .index      (index)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_next;
    logic          rpt_armed;
    logic          rpt_fire;

    // First repeat after REPEAT_DELAY held frames, then every REPEAT_PERIOD.
    assign rpt_next = rpt_cnt + 1'b1;
    assign rpt_fire = rpt_armed ? (rpt_next == RW'(REPEAT_PERIOD))
                                : (rpt_next == RW'(REPEAT_DELAY));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
            key_multi   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_armed   <= 1'b0;
`endif
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (stable) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
`endif
                case (state)
                    IDLE: begin
                        if (is_one) begin
                            state     <= PRESSED;
                            key_held  <= 1'b1;
                            key_code  <= index;
                            key_valid <= 1'b1;
                        end else if (is_multi) begin
                            state     <= MULTI;
                            key_multi <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (is_zero) begin
                            state       <= IDLE;
                            key_held    <= 1'b0;
                            key_release <= 1'b1;
                        end else if (is_multi) begin
                            state       <= MULTI;
                            key_held    <= 1'b0;
                            key_multi   <= 1'b1;
                            key_release <= 1'b1;
                        end else if (index != key_code) begin
                            key_code  <= index;
                            key_valid <= 1'b1;
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            rpt_cnt   <= rpt_fire ? '0 : rpt_next;
                            rpt_armed <= rpt_armed | rpt_fire;
                            key_valid <= rpt_fire;
`endif
                        end
                    end
                    MULTI: begin
                        if (is_zero) begin
                            state     <= IDLE;
                            key_multi <= 1'b0;
                        end else if (is_one) begin
                            state     <= PRESSED;
                            key_multi <= 1'b0;
                            key_held  <= 1'b1;
                            key_code  <= index;
                            key_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        key_held  <= 1'b0;
                        key_multi <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_unit.sv
// Self-checking bench for keypad_scan_unit: directed and random key matrices against a frame-level model.
`timescale 1ns/1ps
module tb_keypad_scan_unit;
    import keypad_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DEB  = 3;
    localparam int RD   = 4;
    localparam int RP   = 2;
    localparam int N    = ROWS * COLS;
    localparam int KW   = $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick_scan = 1'b0;
    logic [ROWS-1:0] key_row;
    logic [COLS-1:0] key_col;
    logic [KW-1:0]   key_code;
    logic            key_valid;
    logic            key_release;
    logic            key_held;
    logic            key_multi;
    logic [N-1:0]    keys = '0;

    typedef struct {
        bit valid;
        bit rel;
        int code;
        bit held;
        bit multi;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [N-1:0] hist[$];
    int n_chk = 0;
    int n_err = 0;
    int exp_valid_cnt = 0, exp_rel_cnt = 0, got_valid_cnt = 0, got_rel_cnt = 0;
    int m_state, m_code, m_hold;
    int tb_col = 0;
    bit [1:0] done_pipe = '0;

    always #5 clk = ~clk;

    keypad_scan_unit #(
        .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_FRAMES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .tick_scan(tick_scan), .key_row(key_row),
        .key_col(key_col), .key_code(key_code), .key_valid(key_valid),
        .key_release(key_release), .key_held(key_held), .key_multi(key_multi)
    );

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        key_row = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!key_col[c] && keys[r*COLS+c]) key_row[r] = 1'b0;
    end

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [N-1:0] kbit(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back('0);
        m_state = 0;
        m_code  = 0;
        m_hold  = 0;
    endtask

    // A frame is accepted once the last max(DEB,2) frames (reset counts as an empty one) agree.
    task automatic model_frame(input logic [N-1:0] set);
        exp_t e;
        int   need;
        bit   stab;
        int   ones;
        int   k;
        hist.push_back(set);
        if (hist.size() > 8) void'(hist.pop_front());
        need = (DEB < 2) ? 2 : DEB;
        stab = (hist.size() >= need);
        for (int i = 1; i < need; i++)
            if (stab && hist[hist.size()-1-i] != set) stab = 0;
        e.valid = 0;
        e.rel   = 0;
        if (stab) begin
            ones = $countones(set);
            if (ones == 0) begin
                e.rel   = (m_state == 1);
                m_state = 0;
            end else if (ones == 1) begin
                k = 0;
                for (int i = 0; i < N; i++) if (set[i]) k = i;
                if (m_state != 1 || k != m_code) begin
                    e.valid = 1;
                    m_code  = k;
                    m_hold  = 0;
                end else begin
                    m_hold++;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) e.valid = 1;
`endif
                end
                m_state = 1;
            end else begin
                e.rel   = (m_state == 1);
                m_state = 2;
            end
        end
        e.code  = m_code;
        e.held  = (m_state == 1);
        e.multi = (m_state == 2);
        exp_valid_cnt += int'(e.valid);
        exp_rel_cnt   += int'(e.rel);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        tick_scan = 1'b1;
        @(posedge clk); #1;
        tick_scan = 1'b0;
    endtask

    task automatic run_frame(input logic [N-1:0] set);
        keys = set;
        for (int c = 0; c < COLS; c++) begin
            if (c == COLS-1) model_frame(set);
            tick($urandom_range(1, 3));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key_col"},     int'(key_col), (1 << COLS) - 1);
        chk({tag, "_key_valid"},   int'(key_valid), 0);
        chk({tag, "_key_release"}, int'(key_release), 0);
        chk({tag, "_key_held"},    int'(key_held), 0);
        chk({tag, "_key_multi"},   int'(key_multi), 0);
        chk({tag, "_key_code"},    int'(key_code), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check_reset_outputs(tag);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_key_col_after"}, int'(key_col), (1 << COLS) - 2);
        @(posedge clk); #1;
        model_reset();
    endtask

    // Bench-side column counter marks the completing tick; outputs are due two edges later.
    always @(posedge clk) begin
        if (rst) begin
            tb_col    = 0;
            done_pipe = '0;
        end else begin
            done_pipe = {done_pipe[0], (tick_scan && tb_col == COLS-1)};
            if (tick_scan) tb_col = (tb_col == COLS-1) ? 0 : tb_col + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid)   got_valid_cnt++;
            if (key_release) got_rel_cnt++;
            if (done_pipe[1]) begin
                if (exp_q.size() == 0) begin
                    chk("exp_queue_underrun", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("key_valid",   int'(key_valid),   int'(mon_e.valid));
                    chk("key_release", int'(key_release), int'(mon_e.rel));
                    chk("key_code",    int'(key_code),    mon_e.code);
                    chk("key_held",    int'(key_held),    int'(mon_e.held));
                    chk("key_multi",   int'(key_multi),   int'(mon_e.multi));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int len;
        logic [N-1:0] s;

        do_reset("por");
        repeat (2) run_frame('0);

        // Press R, then reset part-way through a sweep while it is still held.
        repeat (4) run_frame(kbit(KEY_GEAR_R));
        tick(2);
        tick(2);
        do_reset("mid");
        repeat (6) run_frame(kbit(KEY_GEAR_R));
        repeat (4) run_frame('0);

        // Bounce on N, then settle.
        for (int i = 0; i < 8; i++) run_frame((i % 2 == 0) ? kbit(KEY_GEAR_N) : '0);
        repeat (4) run_frame(kbit(KEY_GEAR_N));
        repeat (4) run_frame('0);

        // P and D together, then P lifted.
        repeat (4) run_frame(kbit(KEY_GEAR_P) | kbit(KEY_GEAR_D));
        repeat (4) run_frame(kbit(KEY_GEAR_D));
        repeat (4) run_frame('0);

        // P straight to R without passing through empty.
        repeat (4) run_frame(kbit(KEY_GEAR_P));
        repeat (4) run_frame(kbit(KEY_GEAR_R));
        repeat (4) run_frame('0);

        repeat (40) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 6);
            if (kind <= 2)      s = '0;
            else if (kind <= 6) s = kbit($urandom_range(0, N-1));
            else                s = kbit($urandom_range(0, N-1)) | kbit($urandom_range(0, N-1));
            if (kind == 9) begin
                for (int i = 0; i < len; i++) run_frame((i % 2 == 0) ? s : '0);
            end else begin
                repeat (len) run_frame(s);
            end
        end
        repeat (4) run_frame('0);

        // Long hold of key 0 (auto-repeat when enabled).
        repeat (14) run_frame(kbit(0));
        repeat (4) run_frame('0);

        repeat (8) begin @(posedge clk); #1; end
        chk("valid_pulse_count",   got_valid_cnt, exp_valid_cnt);
        chk("release_pulse_count", got_rel_cnt,   exp_rel_cnt);
        chk("exp_queue_drained",   exp_q.size(),  0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_scan_unit.md
Name: keypad_scan_unit

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: scans a ROWS x COLS key matrix one column at a time on the shared tick_scan strobe.
- Debounces whole-matrix frames and reports single key presses and releases to the vehicle control logic (gear select, throttle, brake, OBD mode).
- Sits beside the display unit and shares its clk, rst and tick_scan.

Parameters:
- ROWS, 4, number of row inputs.
- COLS, 4, number of column drive outputs.
- DEBOUNCE_FRAMES, 3, consecutive identical full sweeps required before a frame is accepted (>=1).
- REPEAT_DELAY, 20, frames held before the first auto-repeat (optional feature only).
- REPEAT_PERIOD, 5, frames between auto-repeats (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_scan  in  1  one-cycle scan strobe, same source as the display unit.
- key_row  in  ROWS  row sense, active-low (0 = pressed key on the driven column).
- key_col  out  COLS  column drive, one-hot active-low, registered.
- key_code  out  clog2(ROWS*COLS)  index of the accepted key = row*COLS + col; held until the next accepted key.
- key_valid  out  1  one-cycle pulse on each accepted press.
- key_release  out  1  one-cycle pulse when the accepted key is released.
- key_held  out  1  high while in PRESSED.
- key_multi  out  1  high while in MULTI (more than one key stable).

Behaviour:
- Reset (rst sampled high on a clk edge): col_idx=0, key_col=all ones, frame/prev_frame=0, deb_cnt=0, state=IDLE, key_code=0; key_valid, key_release, key_held, key_multi=0. Reset mid-scan discards the partial frame; no release pulse is generated.
- Scan: key_col = ~(1<<col_idx), registered one cycle after col_idx changes. On tick_scan, ~key_row is written into frame bits [col_idx*ROWS +: ROWS], then col_idx advances; it wraps COLS-1 -> 0. Rows therefore settle for a full tick period before sampling.
- Frame end: the tick_scan with col_idx==COLS-1 completes a frame. Evaluate on the following cycle using the completed frame:
  - if frame==prev_frame: deb_cnt saturates upward at DEBOUNCE_FRAMES-1; otherwise deb_cnt=0.
  - prev_frame<=frame.
  - stable = (frame==prev_frame) && deb_cnt==DEBOUNCE_FRAMES-1 (after the increment).
- FSM (updates only on a stable frame end; Z=frame zero, ONE=exactly one bit set, M=two or more bits set):
  - IDLE: ONE -> PRESSED, latch key_code, pulse key_valid. M -> MULTI. Z -> stay.
  - PRESSED: Z -> IDLE, pulse key_release. ONE with a different key -> latch the new code, pulse key_valid, no release pulse. Same key -> stay. M -> MULTI, pulse key_release.
  - MULTI: Z -> IDLE. ONE -> PRESSED, latch, pulse key_valid.
- Pulse timing: key_valid/key_release are asserted exactly one clk, 2 cycles after the completing tick_scan. key_code is valid in the same cycle as key_valid.
- Press latency: at most (DEBOUNCE_FRAMES+1) full sweeps plus 2 clk.
- Bounce: any frame change restarts deb_cnt; no pulses are issued while unstable.
- tick_scan arriving during the frame-end evaluation cycle is still sampled normally; no tick is lost.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: while PRESSED, a frame counter runs on each stable frame end. key_valid re-pulses with the same key_code after REPEAT_DELAY frames, then every REPEAT_PERIOD frames. The counter clears on any state change or key change.
- Undefined: one key_valid per press; REPEAT_* parameters unused and no repeat counter is synthesized.

Decomposition:
- Package keypad_pkg:
  - state encodings IDLE=2'd0, PRESSED=2'd1, MULTI=2'd2;
  - default ROWS/COLS/DEBOUNCE_FRAMES;
  - key-code constants used by the control logic for gear keys P/R/N/D = 3/6/9/12, matching the display unit gear_char codes.
- One sub-module, keypad_frame_debounce: takes the frame and a frame_done strobe, owns prev_frame and deb_cnt, outputs a stable strobe plus the zero/one-hot/multi classification and the encoded index.
- The column scanner and FSM stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles mid-sweep -> key_col=4'b1111, all flags 0. First tick after release samples column 0; key_col=4'b1110 one cycle after rst drops.
- Clean press of row 1, col 2 for 6 frames, DEBOUNCE_FRAMES=3 -> single key_valid with key_code=6 after the 3rd identical frame, key_held=1. Release -> one key_release, key_held=0.
- Bounce: toggle key 9 every other frame for 8 frames, then hold steady -> no pulses during toggling; exactly one key_valid (code 9) after 3 stable frames.
- Two keys 3 and 12 pressed together -> key_multi=1, no key_valid. Release 3 -> key_valid with code 12.
- Key change 3 -> 6 without passing through zero -> key_valid for 6, no key_release.
- KEYPAD_AUTOREPEAT_EN with REPEAT_DELAY=4, REPEAT_PERIOD=2, key 0 held 12 stable frames -> key_valid at stable frames 1, 5, 7, 9, 11.
